cache_slice_loader: RTL and testbench

- Write-side feeder for the L3 voxel cache.
- On each player move it requests the newly exposed slice from the host over the UART TX path, then receives the block bytes on the UART RX path.
- Each received byte becomes one cache write at the correct edge coordinate (relative x/y/z), matching the cache's pointer-relative addressing.
- Sits between the UART RX/TX and the cache write port; the movement controller also drives the cache pointer shift.

---
 rtl/cache_slice_loader.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cache_slice_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_slice_loader.sv
`default_nettype none
// ============================================================================
// Module   : cache_slice_loader
// Purpose  : Write-side feeder for the L3 voxel cache. On a player move it
//            sends a one-byte slice request over the UART TX path. It then
//            turns each byte received on the UART RX path into one cache
//            write at the newly exposed edge of the pointer-relative cache.
// Ports    : clk_in, rst_in      - clock, synchronous active-high reset
//            control_input[3:0]  - one-hot move code (+X,-X,+Z,-Z)
//            control_trigger     - move strobe, qualified by valid_in
//            req_data/valid/ready- request byte handshake towards UART TX
//            rx_data, rx_valid   - byte stream from UART RX
//            xwrite/ywrite/zwrite, write_data, write_enable - cache write port
//            busy, done, error   - status (error is sticky until reset)
// Options  : FULL_LOAD_EN adds input full_load, which reloads the whole cache
//            (request 8'hAF, then LENGTH*HEIGHT*WIDTH bytes in x,y,z order).
// Revision : 1.0 - initial release
// ============================================================================
module cache_slice_loader #(
  parameter int LENGTH = 64,
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [3:0]                control_input,
  input  logic                      control_trigger,
  input  logic                      valid_in,
`ifdef FULL_LOAD_EN
  input  logic                      full_load,
`endif
  output logic [7:0]                req_data,
  output logic                      req_valid,
  input  logic                      req_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [$clog2(LENGTH)-1:0] xwrite,
  output logic [$clog2(HEIGHT)-1:0] ywrite,
  output logic [$clog2(WIDTH)-1:0]  zwrite,
  output logic [4:0]                write_data,
  output logic                      write_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int c_x_bits = $clog2(LENGTH);
  localparam int c_y_bits = $clog2(HEIGHT);
  localparam int c_z_bits = $clog2(WIDTH);

  localparam logic [c_x_bits-1:0] c_x_max = c_x_bits'(LENGTH - 1);
  localparam logic [c_y_bits-1:0] c_y_max = c_y_bits'(HEIGHT - 1);
  localparam logic [c_z_bits-1:0] c_z_max = c_z_bits'(WIDTH - 1);

  // Transfer modes; the slice modes double as the low nibble of the request.
  localparam logic [2:0] c_mode_none = 3'd0;
  localparam logic [2:0] c_mode_px   = 3'd1;
  localparam logic [2:0] c_mode_mx   = 3'd2;
  localparam logic [2:0] c_mode_pz   = 3'd3;
  localparam logic [2:0] c_mode_mz   = 3'd4;
  localparam logic [2:0] c_mode_full = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND_REQ = 2'd1,
    S_RECV     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                r_state;
  logic [2:0]            r_mode;
  logic [c_x_bits-1:0]   r_cx;
  logic [c_y_bits-1:0]   r_cy;
  logic [c_z_bits-1:0]   r_cz;
  logic                  r_last_pending;

  logic [7:0]            r_req_data;
  logic                  r_req_valid;
  logic [c_x_bits-1:0]   r_xwrite;
  logic [c_y_bits-1:0]   r_ywrite;
  logic [c_z_bits-1:0]   r_zwrite;
  logic [4:0]            r_write_data;
  logic                  r_write_enable;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_move_strobe;
  logic                  w_full_strobe;
  logic [2:0]            w_move_mode;
  logic                  w_bad_byte;
  logic [c_x_bits-1:0]   w_cx_nxt;
  logic [c_y_bits-1:0]   w_cy_nxt;
  logic [c_z_bits-1:0]   w_cz_nxt;
  logic                  w_last;

  assign w_move_strobe = valid_in && control_trigger;
`ifdef FULL_LOAD_EN
  assign w_full_strobe = full_load;
`else
  assign w_full_strobe = 1'b0;
`endif

  // Block IDs are 5 bits; anything with the top bits set is not a block.
  assign w_bad_byte = (rx_data[7:5] != 3'b000);

  // Decode the move code; codes that are not one-hot map to "none".
  always_comb begin
    w_move_mode = c_mode_none;
    case (control_input)
      4'b0001: w_move_mode = c_mode_px;
      4'b0010: w_move_mode = c_mode_mx;
      4'b0100: w_move_mode = c_mode_pz;
      4'b1000: w_move_mode = c_mode_mz;
      default: w_move_mode = c_mode_none;
    endcase
  end

  // Coordinate walk. The fixed coordinate of a slice is loaded at accept time
  // and simply never advances, so the counters drive the write address as-is.
  always_comb begin
    w_cx_nxt = r_cx;
    w_cy_nxt = r_cy;
    w_cz_nxt = r_cz;
    w_last   = 1'b0;
    case (r_mode)
      c_mode_px, c_mode_mx: begin
        w_last = (r_cy == c_y_max) && (r_cz == c_z_max);
        if (r_cz == c_z_max) begin
          w_cz_nxt = '0;
          w_cy_nxt = r_cy + 1'b1;
        end else begin
          w_cz_nxt = r_cz + 1'b1;
        end
      end
      c_mode_pz, c_mode_mz: begin
        w_last = (r_cy == c_y_max) && (r_cx == c_x_max);
        if (r_cx == c_x_max) begin
          w_cx_nxt = '0;
          w_cy_nxt = r_cy + 1'b1;
        end else begin
          w_cx_nxt = r_cx + 1'b1;
        end
      end
      c_mode_full: begin
        w_last = (r_cx == c_x_max) && (r_cy == c_y_max) && (r_cz == c_z_max);
        if (r_cz == c_z_max) begin
          w_cz_nxt = '0;
          if (r_cy == c_y_max) begin
            w_cy_nxt = '0;
            w_cx_nxt = r_cx + 1'b1;
          end else begin
            w_cy_nxt = r_cy + 1'b1;
          end
        end else begin
          w_cz_nxt = r_cz + 1'b1;
        end
      end
      default: begin
        w_last = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= S_IDLE;
      r_mode         <= c_mode_none;
      r_cx           <= '0;
      r_cy           <= '0;
      r_cz           <= '0;
      r_last_pending <= 1'b0;
      r_req_data     <= 8'h00;
      r_req_valid    <= 1'b0;
      r_xwrite       <= '0;
      r_ywrite       <= '0;
      r_zwrite       <= '0;
      r_write_data   <= 5'd0;
      r_write_enable <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_write_enable <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_error <= 1'b1;
          end
          // A full reload wins over a move arriving in the same cycle.
          if (w_full_strobe) begin
            r_mode      <= c_mode_full;
            r_cx        <= '0;
            r_cy        <= '0;
            r_cz        <= '0;
            r_req_data  <= 8'hAF;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_SEND_REQ;
          end else if (w_move_strobe && (w_move_mode != c_mode_none)) begin
            r_mode      <= w_move_mode;
            r_cx        <= (w_move_mode == c_mode_px) ? c_x_max : '0;
            r_cy        <= '0;
            r_cz        <= (w_move_mode == c_mode_pz) ? c_z_max : '0;
            r_req_data  <= 8'hA0 | {5'd0, w_move_mode};
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_SEND_REQ;
          end
        end

        S_SEND_REQ: begin
          if (rx_valid || w_move_strobe || w_full_strobe) begin
            r_error <= 1'b1;
          end
          if (req_ready) begin
            r_req_valid <= 1'b0;
            r_req_data  <= 8'h00;
            r_state     <= S_RECV;
          end
        end

        S_RECV: begin
          if (w_move_strobe || w_full_strobe) begin
            r_error <= 1'b1;
          end
          if (r_last_pending) begin
            // The final write is on the port this cycle; any further byte
            // belongs to no slice.
            if (rx_valid) begin
              r_error <= 1'b1;
            end
            r_last_pending <= 1'b0;
            r_done         <= 1'b1;
            r_state        <= S_DONE;
          end else if (rx_valid) begin
            r_write_enable <= 1'b1;
            r_xwrite       <= r_cx;
            r_ywrite       <= r_cy;
            r_zwrite       <= r_cz;
            r_write_data   <= w_bad_byte ? 5'd0 : rx_data[4:0];
            if (w_bad_byte) begin
              r_error <= 1'b1;
            end
            r_cx <= w_cx_nxt;
            r_cy <= w_cy_nxt;
            r_cz <= w_cz_nxt;
            if (w_last) begin
              r_last_pending <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (rx_valid || w_move_strobe || w_full_strobe) begin
            r_error <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_mode  <= c_mode_none;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_data     = r_req_data;
  assign req_valid    = r_req_valid;
  assign xwrite       = r_xwrite;
  assign ywrite       = r_ywrite;
  assign zwrite       = r_zwrite;
  assign write_data   = r_write_data;
  assign write_enable = r_write_enable;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cache_slice_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_slice_loader
// Purpose  : Self-checking bench for cache_slice_loader with a 4x4x4 cache.
//            Stimulus pushes expected requests and writes into queues; an
//            independent monitor pops and compares them as the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_slice_loader;

  localparam int L = 4;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] control_input = 4'd0;
  logic       control_trigger = 1'b0;
  logic       valid_in = 1'b0;
`ifdef FULL_LOAD_EN
  logic       full_load = 1'b0;
`endif
  logic [7:0] req_data;
  logic       req_valid;
  logic       req_ready = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [1:0] xwrite;
  logic [1:0] ywrite;
  logic [1:0] zwrite;
  logic [4:0] write_data;
  logic       write_enable;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clk_in = ~clk_in;

  cache_slice_loader #(.LENGTH(L), .WIDTH(W), .HEIGHT(H)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .control_input   (control_input),
    .control_trigger (control_trigger),
    .valid_in        (valid_in),
`ifdef FULL_LOAD_EN
    .full_load       (full_load),
`endif
    .req_data        (req_data),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .xwrite          (xwrite),
    .ywrite          (ywrite),
    .zwrite          (zwrite),
    .write_data      (write_data),
    .write_enable    (write_enable),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  typedef struct {
    int x;
    int y;
    int z;
    int d;
  } wr_t;

  wr_t        coord_q[$];   // addresses still to be used by the current slice
  wr_t        exp_wr[$];    // writes expected on the cache port
  logic [7:0] exp_req[$];   // request bytes expected on the TX port
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  tb_wr = 1'b0;        // the byte being driven must produce a write
  bit  tb_err = 1'b0;       // reference value of the sticky error flag
  int  exp_done = 0;
  int  got_done = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit  we_exp;
    wr_t e;
    forever begin
      @(negedge clk_in);
      #1;
      if (req_valid) begin
        if (exp_req.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_unexpected: got 0x%02h expected no request", req_data);
        end else begin
          chk("req_data", req_data, exp_req[0]);
          if (req_ready) void'(exp_req.pop_front());
        end
      end
      we_exp = rx_valid && tb_wr && !rst_in;
      @(posedge clk_in);
      #1;
      if (we_exp || write_enable) begin
        chk("write_enable", write_enable, we_exp);
        if (we_exp && write_enable) begin
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_unexpected: got a write expected none");
          end else begin
            e = exp_wr.pop_front();
            chk("xwrite", xwrite, e.x);
            chk("ywrite", ywrite, e.y);
            chk("zwrite", zwrite, e.z);
            chk("write_data", write_data, e.d);
          end
        end
      end
      if (done) got_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  // Builds the slice address list and request byte from the move rules.
  task automatic plan_move(input logic [3:0] code);
    wr_t c;
    int  inner;
    inner = (code == 4'b0001 || code == 4'b0010) ? W : L;
    for (int y = 0; y < H; y++) begin
      for (int i = 0; i < inner; i++) begin
        c.y = y;
        c.d = 0;
        case (code)
          4'b0001: begin c.x = L - 1; c.z = i; end
          4'b0010: begin c.x = 0;     c.z = i; end
          4'b0100: begin c.x = i;     c.z = W - 1; end
          default: begin c.x = i;     c.z = 0; end
        endcase
        coord_q.push_back(c);
      end
    end
    case (code)
      4'b0001: exp_req.push_back(8'hA1);
      4'b0010: exp_req.push_back(8'hA2);
      4'b0100: exp_req.push_back(8'hA3);
      default: exp_req.push_back(8'hA4);
    endcase
  endtask

  task automatic wait_req_sent();
    for (int k = 0; k < 100; k++) begin
      if (exp_req.size() == 0) break;
      @(negedge clk_in);
      #2;
    end
    if (exp_req.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: got no transfer expected 0x%02h", exp_req[0]);
      exp_req.delete();
    end
  endtask

  task automatic start_move(input logic [3:0] code, input int stall);
    @(negedge clk_in);
    plan_move(code);
    valid_in = 1'b1;
    control_trigger = 1'b1;
    control_input = code;
    req_ready = (stall == 0);
    @(negedge clk_in);
    valid_in = 1'b0;
    control_trigger = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (i > 0) @(negedge clk_in);
      #1;
      chk("stall_req_valid", req_valid, 1);
      chk("stall_req_data", req_data, exp_req[0]);
    end
    if (stall > 0) begin
      @(negedge clk_in);
      req_ready = 1'b1;
    end
    wait_req_sent();
  endtask

  // Drives one RX byte that belongs to the current slice.
  task automatic drive_byte(input logic [7:0] b);
    wr_t e;
    @(negedge clk_in);
    rx_data = b;
    rx_valid = 1'b1;
    tb_wr = 1'b1;
    e = coord_q.pop_front();
    e.d = (b[7:5] != 3'b000) ? 0 : int'(b[4:0]);
    if (b[7:5] != 3'b000) tb_err = 1'b1;
    exp_wr.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk_in);
    rx_valid = 1'b0;
    tb_wr = 1'b0;
    valid_in = 1'b0;
    control_trigger = 1'b0;
  endtask

  task automatic finish_slice();
    idle_cycle();
    @(posedge clk_in);
    #1;
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    exp_done++;
    @(posedge clk_in);
    #1;
    chk("done_cleared", done, 0);
    chk("busy_after", busy, 0);
    chk("error_after_slice", error, tb_err);
  endtask

  // kind 0: bytes 0,1,2..; kind 1: random valid IDs; kind 2: random 8-bit.
  task automatic send_slice(input int kind, input int bad_idx,
                            input int strobe_idx, input int max_gap);
    int n;
    logic [7:0] b;
    n = coord_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) idle_cycle();
      case (kind)
        0:       b = 8'(i);
        1:       b = 8'($urandom_range(0, 31));
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (i == bad_idx) b = 8'h25;
      drive_byte(b);
      valid_in = (i == strobe_idx);
      control_trigger = (i == strobe_idx);
      if (i == strobe_idx) begin
        control_input = 4'b0001;
        tb_err = 1'b1;
      end
    end
    finish_slice();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wr_t c;
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_req_data", req_data, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_xwrite", xwrite, 0);
    chk("rst_ywrite", ywrite, 0);
    chk("rst_zwrite", zwrite, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Non-one-hot code: ignored silently.
    @(negedge clk_in);
    valid_in = 1'b1;
    control_trigger = 1'b1;
    control_input = 4'b0011;
    idle_cycle();
    repeat (2) @(negedge clk_in);
    #1;
    chk("nonhot_busy", busy, 0);
    chk("nonhot_error", error, 0);

    // +X, ready tied high, bytes 0..15 back to back.
    start_move(4'b0001, 0);
    send_slice(0, -1, -1, 0);

    // -Z with a five-cycle TX stall, random valid bytes with gaps.
    start_move(4'b1000, 5);
    send_slice(1, -1, -1, 2);

    // Invalid byte mid-slice.
    start_move(4'b0010, 1);
    send_slice(1, 6, -1, 1);

    // Move strobe during RECV.
    start_move(4'b0100, 0);
    send_slice(1, -1, 9, 1);

    // Reset after 7 of 16 bytes.
    start_move(4'b0001, 0);
    for (int i = 0; i < 7; i++) drive_byte(8'(i + 3));
    @(negedge clk_in);
    rx_valid = 1'b0;
    tb_wr = 1'b0;
    rst_in = 1'b1;
    coord_q.delete();
    tb_err = 1'b0;
    @(posedge clk_in);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_write_enable", write_enable, 0);
    chk("midrst_error", error, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_in);
      rx_data = 8'(i);
      rx_valid = 1'b1;
      tb_wr = 1'b0;
    end
    tb_err = 1'b1;
    idle_cycle();
    repeat (3) @(negedge clk_in);
    #1;
    chk("postrst_busy", busy, 0);
    chk("postrst_error", error, 1);

    // Randomized slices.
    for (int t = 0; t < 6; t++) begin
      logic [3:0] code;
      code = 4'b0001 << $urandom_range(0, 3);
      start_move(code, $urandom_range(0, 3));
      send_slice(2, -1, -1, 2);
    end

`ifdef FULL_LOAD_EN
    // Full reload, with a competing move in the same cycle.
    @(negedge clk_in);
    for (int x = 0; x < L; x++)
      for (int y = 0; y < H; y++)
        for (int z = 0; z < W; z++) begin
          c.x = x; c.y = y; c.z = z; c.d = 0;
          coord_q.push_back(c);
        end
    exp_req.push_back(8'hAF);
    full_load = 1'b1;
    valid_in = 1'b1;
    control_trigger = 1'b1;
    control_input = 4'b0001;
    @(negedge clk_in);
    full_load = 1'b0;
    valid_in = 1'b0;
    control_trigger = 1'b0;
    wait_req_sent();
    send_slice(1, -1, -1, 1);
`else
    c.x = 0;
`endif

    repeat (4) @(negedge clk_in);
    chk("leftover_writes", exp_wr.size(), 0);
    chk("leftover_reqs", exp_req.size(), 0);
    chk("done_count", got_done, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
